// File: rtl/operand_entry_ctrl.sv
// Operator-input stage: debounces the enter button, captures two signed operands
// from a shared switch bank and hands them to the Booth multiplier with a start pulse.
module operand_entry_ctrl #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit CHECK_PARAM     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter_n,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             mult_ready,
    output logic             start_n,
    output logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic [2:0]       state_led
);

    if (CHECK_PARAM && (WIDTH == 0 || DEBOUNCE_CYCLES == 0)) begin : g_param_check
        $fatal(1, "operand_entry_ctrl: WIDTH and DEBOUNCE_CYCLES must both be non-zero");
    end

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        GET_B    = 3'd1,
        START    = 3'd2,
        WAIT_RES = 3'd3,
        SHOW     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             enter_meta_q, enter_sync_q;
    logic             clr_meta_q, clr_sync_q;
    logic [WIDTH-1:0] sw_meta_q, sw_sync_q;
    logic             ready_q;
    logic             enter_deb_q, enter_deb_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             start_n_q, start_n_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             press_evt;
    logic             ready_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enter_meta_q <= 1'b1;
            enter_sync_q <= 1'b1;
            clr_meta_q   <= 1'b1;
            clr_sync_q   <= 1'b1;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            ready_q      <= 1'b0;
            enter_deb_q  <= 1'b1;
            deb_cnt_q    <= '0;
        end else begin
            enter_meta_q <= enter_n;
            enter_sync_q <= enter_meta_q;
            clr_meta_q   <= clr_n;
            clr_sync_q   <= clr_meta_q;
            sw_meta_q    <= sw;
            sw_sync_q    <= sw_meta_q;
            ready_q      <= mult_ready;
            enter_deb_q  <= enter_deb_d;
            deb_cnt_q    <= deb_cnt_d;
        end
    end

    // The flip cycle itself is the press event, so the FSM acts on the same edge
    // that the debounced level changes.
    always_comb begin
        enter_deb_d = enter_deb_q;
        deb_cnt_d   = '0;
        press_evt   = 1'b0;
        if (enter_sync_q != enter_deb_q) begin
            if (deb_cnt_q == CNT_LAST) begin
                enter_deb_d = enter_sync_q;
                press_evt   = enter_deb_q & ~enter_sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ready_rise = ~ready_q & mult_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= GET_A;
            start_n_q <= 1'b1;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            state_q   <= state_d;
            start_n_q <= start_n_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (!clr_sync_q) begin
            state_d  = GET_A;
            mcand_d  = '0;
            mplier_d = '0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (press_evt) begin
                        mcand_d = sw_sync_q;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (press_evt) begin
                        mplier_d = sw_sync_q;
                        state_d  = START;
                    end
                end
                START:    state_d = WAIT_RES;
                // Only a fresh rising edge counts; a ready left high by the last result is stale.
                WAIT_RES: if (ready_rise) state_d = SHOW;
                SHOW: begin
                    if (press_evt) begin
                        mcand_d = sw_sync_q;
                        state_d = GET_B;
                    end
                end
                default:  state_d = GET_A;
            endcase
        end
        start_n_d = (state_d != START);
    end

    assign start_n      = start_n_q;
    assign multiplicand = mcand_q;
    assign multiplier   = mplier_q;
    assign busy         = (state_q == START) || (state_q == WAIT_RES);
    assign state_led    = {state_q == SHOW, state_q == GET_B, state_q == GET_A};

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl with DEBOUNCE_CYCLES = 4; a press needs
// 2 synchronizer + 4 debounce edges before the state machine reacts.
module tb_operand_entry_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enter_n;
    logic       clr_n;
    logic [4:0] sw;
    logic       mult_ready;
    logic       start_n;
    logic [4:0] multiplicand;
    logic [4:0] multiplier;
    logic       busy;
    logic [2:0] state_led;

    int checks   = 0;
    int failures = 0;
    int lows;
    int bad;

    operand_entry_ctrl #(
        .WIDTH          (5),
        .DEBOUNCE_CYCLES(4),
        .CHECK_PARAM    (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enter_n     (enter_n),
        .clr_n       (clr_n),
        .sw          (sw),
        .mult_ready  (mult_ready),
        .start_n     (start_n),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .state_led   (state_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enter_n    = 1'b1;
        clr_n      = 1'b1;
        sw         = 5'd0;
        mult_ready = 1'b0;
        tick(3);
        chk("rst_start_n", 32'(start_n), 32'd1);
        chk("rst_mcand", 32'(multiplicand), 32'd0);
        chk("rst_mplier", 32'(multiplier), 32'd0);
        chk("rst_led", 32'(state_led), 32'b001);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Operand A = 3
        sw = 5'b00011; enter_n = 1'b0;
        tick(5);
        chk("a_not_yet", 32'(state_led), 32'b001);
        tick(1);
        chk("a_led", 32'(state_led), 32'b010);
        chk("a_val", 32'(multiplicand), 32'd3);
        tick(4);
        enter_n = 1'b1;
        tick(8);

        // Operand B = -3, start pulse exactly one cycle
        sw = 5'b11101; enter_n = 1'b0;
        tick(5);
        chk("b_not_yet_start", 32'(start_n), 32'd1);
        chk("b_not_yet_led", 32'(state_led), 32'b010);
        tick(1);
        chk("start_low", 32'(start_n), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("b_val", 32'(multiplier), 32'h1D);
        chk("b_keep_a", 32'(multiplicand), 32'd3);
        chk("start_led", 32'(state_led), 32'b000);
        tick(1);
        chk("start_one_cycle", 32'(start_n), 32'd1);
        chk("wait_busy", 32'(busy), 32'd1);
        enter_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            if (!start_n) lows++;
        end
        chk("wait_no_start", 32'(lows), 32'd0);
        chk("wait_led", 32'(state_led), 32'b000);
        mult_ready = 1'b1;
        tick(1);
        chk("show_led", 32'(state_led), 32'b100);
        chk("show_busy", 32'(busy), 32'd0);
        chk("show_mcand", 32'(multiplicand), 32'd3);
        tick(2);

        // Re-entry from SHOW
        sw = 5'b01111; enter_n = 1'b0;
        tick(6);
        chk("reentry_led", 32'(state_led), 32'b010);
        chk("reentry_mcand", 32'(multiplicand), 32'h0F);
        chk("reentry_mplier", 32'(multiplier), 32'h1D);
        enter_n = 1'b1;
        tick(8);

        // B = 2 while ready is still high from the previous result
        sw = 5'b00010; enter_n = 1'b0;
        tick(6);
        chk("b2_start", 32'(start_n), 32'd0);
        tick(1);
        chk("b2_stale_ready_led", 32'(state_led), 32'b000);
        chk("b2_stale_ready_busy", 32'(busy), 32'd1);
        enter_n = 1'b1;
        tick(8);

        // Three presses in WAIT_RES are discarded
        lows = 0; bad = 0;
        for (int p = 0; p < 3; p++) begin
            enter_n = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick(1);
                if (!start_n) lows++;
                if (!busy || state_led != 3'b000) bad++;
            end
            enter_n = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick(1);
                if (!start_n) lows++;
                if (!busy || state_led != 3'b000) bad++;
            end
        end
        chk("ign_no_start", 32'(lows), 32'd0);
        chk("ign_stay_wait", 32'(bad), 32'd0);
        chk("ign_mcand", 32'(multiplicand), 32'h0F);
        chk("ign_mplier", 32'(multiplier), 32'd2);
        mult_ready = 1'b0;
        tick(1);
        chk("ign_ready_low_busy", 32'(busy), 32'd1);
        mult_ready = 1'b1;
        tick(1);
        chk("ign_ready_rise_led", 32'(state_led), 32'b100);

        // Clear after capturing A = 7
        sw = 5'b00111; enter_n = 1'b0;
        tick(6);
        chk("clrA_led_b", 32'(state_led), 32'b010);
        chk("clrA_mcand", 32'(multiplicand), 32'd7);
        enter_n = 1'b1;
        tick(8);
        clr_n = 1'b0;
        tick(2);
        chk("clrA_sync_delay", 32'(state_led), 32'b010);
        tick(1);
        chk("clrA_led", 32'(state_led), 32'b001);
        chk("clrA_mcand0", 32'(multiplicand), 32'd0);
        chk("clrA_mplier0", 32'(multiplier), 32'd0);
        chk("clrA_start_n", 32'(start_n), 32'd1);
        clr_n = 1'b1;
        tick(3);

        // Clear during WAIT_RES, later ready rise ignored
        sw = 5'b00001; enter_n = 1'b0;
        tick(6);
        enter_n = 1'b1;
        tick(8);
        sw = 5'b00011; enter_n = 1'b0;
        tick(6);
        chk("clrW_start", 32'(start_n), 32'd0);
        tick(1);
        chk("clrW_in_wait", 32'(busy), 32'd1);
        mult_ready = 1'b0; clr_n = 1'b0; enter_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            if (!start_n) lows++;
        end
        chk("clrW_led", 32'(state_led), 32'b001);
        chk("clrW_mcand0", 32'(multiplicand), 32'd0);
        chk("clrW_mplier0", 32'(multiplier), 32'd0);
        chk("clrW_busy", 32'(busy), 32'd0);
        clr_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            if (!start_n) lows++;
        end
        mult_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (!start_n) lows++;
        end
        chk("clrW_no_start", 32'(lows), 32'd0);
        chk("clrW_ready_ignored", 32'(state_led), 32'b001);

        // Bounce: toggle every 2 cycles, then hold -> one event after 2 + 4 edges
        sw = 5'b10110; bad = 0;
        for (int t = 0; t < 10; t++) begin
            enter_n = (t % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
            if (state_led != 3'b001) bad++;
        end
        chk("bounce_no_event", 32'(bad), 32'd0);
        enter_n = 1'b0;
        tick(5);
        chk("bounce_hold_early", 32'(state_led), 32'b001);
        tick(1);
        chk("bounce_hold_event", 32'(state_led), 32'b010);
        chk("bounce_mcand", 32'(multiplicand), 32'h16);
        tick(12);
        chk("bounce_single_event", 32'(state_led), 32'b010);
        chk("bounce_no_start", 32'(start_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
